// File: rtl/sumador_serial_pkg.sv
// sumador_serial_pkg: shared types and constants for the bit-serial
// add/subtract sequencer.
//   state_t    - sequencer states (IDLE, SHIFT, DONE)
//   WIDTH_DEF  - default operand/result width
//   cnt_width  - bit-counter width for a given operand width
package sumador_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF = 8;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sumador_serial_ctrl_if.sv
// sumador_serial_ctrl_if: request/response bundle of the serial adder.
//   start, sub, op_a, op_b         - request (driven by master)
//   result, carry_out, overflow,
//   busy, done                     - response (driven by slave)
// Modports: master (requester), slave (sequencer).
interface sumador_serial_ctrl_if
  import sumador_serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, op_a, op_b,
    input  result, carry_out, overflow, busy, done
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output result, carry_out, overflow, busy, done
  );

endinterface

// File: rtl/registro_desplazamiento.sv
// registro_desplazamiento: right-shift register with parallel load and
// serial input entering the MSB. Load has priority over shift.
//   clk, rst    - clock, asynchronous active-high reset
//   load_i      - parallel load of load_val_i
//   shift_i     - shift right by one, ser_i into MSB
//   ser_i       - serial input
//   load_val_i  - parallel load value
//   q_o         - register contents
module registro_desplazamiento #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         ser_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_val_i;
    end else if (shift_i) begin
      sr_q <= {ser_i, sr_q[W-1:1]};
    end
  end

  assign q_o = sr_q;

endmodule

// File: rtl/sumador_serial_ctrl.sv
// sumador_serial_ctrl: bit-serial add/subtract sequencer feeding an external
// combinational 1-bit adder cell, LSB first, one bit per clock.
//   clk, rst          - clock, asynchronous active-high reset
//   bus (slave)       - start/sub/op_a/op_b request; result/carry_out/
//                       overflow/busy/done response
//   bit_a, bit_b      - operand bits to the cell (bit_b inverted for sub)
//   bit_ci            - carry-in to the cell (carry register)
//   bit_sel           - 0 while the cell is in use, 1 when idle
//   bit_o, bit_co     - sum and carry-out from the cell, same cycle
// Optional feature: define SUMADOR_SERIAL_OVF_EN to capture signed overflow;
// otherwise overflow is tied to 0.
module sumador_serial_ctrl
  import sumador_serial_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sumador_serial_ctrl_if.slave bus,
  output logic                 bit_a,
  output logic                 bit_b,
  output logic                 bit_ci,
  output logic                 bit_sel,
  input  logic                 bit_o,
  input  logic                 bit_co
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             accept, shifting, last;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             unused_bits;

  // Subtraction is A + ~B + 1: invert B on load, carry register starts at 1.
  registro_desplazamiento #(.W(WIDTH)) u_sr_a (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shifting),
    .ser_i(1'b0), .load_val_i(bus.op_a), .q_o(a_q)
  );

  registro_desplazamiento #(.W(WIDTH)) u_sr_b (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shifting),
    .ser_i(1'b0), .load_val_i(bus.sub ? ~bus.op_b : bus.op_b), .q_o(b_q)
  );

  registro_desplazamiento #(.W(WIDTH)) u_sr_r (
    .clk(clk), .rst(rst), .load_i(accept), .shift_i(shifting),
    .ser_i(bit_o), .load_val_i('0), .q_o(r_q)
  );

  // Only the LSBs of A/B and the upper bits of the result register are read.
  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], r_q[0]};

  assign shifting = (state_q == SHIFT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    accept   = 1'b0;
    last     = 1'b0;
    bit_a    = 1'b0;
    bit_b    = 1'b0;
    bit_ci   = 1'b0;
    bit_sel  = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
          cnt_d   = '0;
          carry_d = bus.sub;
        end
      end
      SHIFT: begin
        bit_a   = a_q[0];
        bit_b   = b_q[0];
        bit_ci  = carry_q;
        bit_sel = 1'b0;
        carry_d = bit_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Final bit: the result register already shifts this edge, so the
          // visible result is assembled from its next value directly.
          last     = 1'b1;
          state_d  = DONE;
          result_d = {bit_o, r_q[WIDTH-1:1]};
          cout_d   = bit_co;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

`ifdef SUMADOR_SERIAL_OVF_EN
  logic ovf_q;

  // Carry into MSB xor carry out of MSB, both visible on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= carry_q ^ bit_co;
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: doc/sumador_serial_ctrl.md
# sumador_serial_ctrl

Bit-serial add/subtract sequencer placed directly upstream of the 1-bit adder cell. It accepts two WIDTH-bit operands and shifts them LSB-first into the cell, one bit per clock, while holding the running carry in a register. It collects the cell's sum bit each cycle and presents the full WIDTH-bit result with a one-cycle done pulse. It turns the combinational 1-bit cell into a multi-bit arithmetic unit.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A−B; sampled with start
- op_a  in  WIDTH  operand A; sampled with start
- op_b  in  WIDTH  operand B; sampled with start
- bit_a  out  1  A bit to cell
- bit_b  out  1  B bit to cell, inverted when sub
- bit_ci  out  1  carry-in to cell, equal to the carry register
- bit_sel  out  1  cell select: 0 = add active, 1 = cell idle
- bit_o  in  1  sum bit from cell, combinational, same cycle
- bit_co  in  1  carry-out from cell, combinational, same cycle
- result  out  WIDTH  final sum/difference; held until next accepted start
- carry_out  out  1  final carry; for sub, 1 = no borrow
- overflow  out  1  signed overflow (see Configuration)
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse, result valid

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE to SHIFT on start:
  - Load a_sr = op_a.
  - Load b_sr = sub ? ~op_b : op_b.
  - Set carry_q = sub and cnt = 0.
  - Clear the result shift register.
- SHIFT, each cycle:
  - bit_a = a_sr[0], bit_b = b_sr[0], bit_ci = carry_q, bit_sel = 0.
  - At the edge: a_sr and b_sr shift right, result shifts right with bit_o entering the MSB, carry_q <= bit_co, cnt++.
- SHIFT to DONE when cnt == WIDTH−1 at the edge, so exactly WIDTH SHIFT cycles.
- DONE: done = 1 for one cycle, then go to IDLE unconditionally.
- Outside SHIFT: bit_sel = 1 and bit_a/b/ci = 0.
- start outside IDLE is ignored, with no queueing; start in the DONE cycle is also ignored.
- Arithmetic is modulo 2^WIDTH. carry_out is the final carry_q.
- Reset values: all outputs 0 except bit_sel = 1. Registers clear and state = IDLE.
- Reset mid-operation aborts at once. done is not pulsed and result reads 0.

## Timing
- Start accepted at edge 0. SHIFT occupies cycles 1..WIDTH. done is high in cycle WIDTH+1.
- Total latency is WIDTH+1 cycles from accept to done.
- result, carry_out and overflow update at the edge that enters DONE and hold stable until the next accepted start.
- busy rises the cycle after accept and falls when returning to IDLE.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- The cell is combinational. bit_o/bit_co must settle within the same cycle; there are no pipeline registers on the cell path.

## Configuration
- SUMADOR_SERIAL_OVF_EN
  - Defined: on the final SHIFT cycle, capture overflow = carry_q XOR bit_co (carry into MSB XOR carry out). Registered and held like result.
  - Undefined: the overflow port remains but is tied to 0 and the capture logic is absent.

## Structure
- Package sumador_serial_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the default WIDTH constant;
  - the counter width function clog2(WIDTH).
- One natural sub-module: registro_desplazamiento, a parameterised right-shift register with parallel load and serial input. Instantiate it three times: A, B, result.
- The FSM, counter and carry register stay in the top module.
- The 1-bit adder cell is not instantiated here; it connects at the next level.

## Test plan
- WIDTH=8, with the cell modelled as a full adder.
- sub=0, A=0x35, B=0x4A -> done at cycle 9; result=0x7F, carry_out=0, overflow=0.
- sub=0, A=0xFF, B=0x01 -> result=0x00, carry_out=1, overflow=0.
- sub=1, A=0x10, B=0x01 -> result=0x0F, carry_out=1. Then A=0x01, B=0x02 -> result=0xFF, carry_out=0.
- With SUMADOR_SERIAL_OVF_EN: sub=0, A=0x7F, B=0x01 -> result=0x80, overflow=1. Without the macro: overflow=0.
- start pulsed again in cycles 3 and 9 of an operation -> ignored; a single done; result from the first operands only.
- rst asserted in cycle 4 of SHIFT -> all outputs at reset values next cycle; no done. A new start afterwards completes normally.
